// File: rtl/div_issue_ctrl_if.sv
// Handshake bundle between the EX-stage divide sequencer (master) and the
// multi-cycle divider (slave); names keep the sequencer's point of view.
interface div_issue_ctrl_if;
   logic        div_start_o;
   logic        div_annul_o;
   logic        div_signed_o;
   logic [31:0] div_opdata1_o;
   logic [31:0] div_opdata2_o;
   logic [63:0] div_result_i;
   logic        div_ready_i;

   modport master (
      output div_start_o, div_annul_o, div_signed_o, div_opdata1_o, div_opdata2_o,
      input  div_result_i, div_ready_i
   );

   modport slave (
      input  div_start_o, div_annul_o, div_signed_o, div_opdata1_o, div_opdata2_o,
      output div_result_i, div_ready_i
   );
endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage DIV/DIVU sequencer: launches the divider once per instruction, stalls
// until the result arrives, then writes HI/LO. Optional macro: DIV_WATCHDOG_EN.
module div_issue_ctrl #(
   parameter int WDOG_LIMIT = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   issue_valid_i,
   input  logic                   issue_signed_i,
   input  logic [31:0]            issue_op1_i,
   input  logic [31:0]            issue_op2_i,
   input  logic                   flush_i,
   output logic                   stallreq_o,
   div_issue_ctrl_if.master       div,
   output logic                   hilo_we_o,
   output logic [31:0]            hi_o,
   output logic [31:0]            lo_o,
   output logic                   dbz_o,
   output logic                   wdog_err_o
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t state, state_next;
   logic   done_q;
   logic   launch, finish, kill, wdog_trip, wdog_hit;

   if (WDOG_LIMIT < 2) begin : g_bad_limit
      $error("div_issue_ctrl: WDOG_LIMIT must be at least 2");
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      launch     = 1'b0;
      finish     = 1'b0;
      kill       = 1'b0;
      wdog_trip  = 1'b0;
      stallreq_o = 1'b0;
      hilo_we_o  = 1'b0;
      case (state)
         IDLE: begin
            stallreq_o = issue_valid_i & ~flush_i;
            if (issue_valid_i && !flush_i) begin
               launch     = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            stallreq_o = 1'b1;
            // Flush wins over a result landing in the same cycle.
            if (flush_i) begin
               kill       = 1'b1;
               state_next = IDLE;
            end else if (div.div_ready_i) begin
               finish     = 1'b1;
               state_next = DONE;
            end else if (wdog_hit) begin
               wdog_trip  = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            // Always fall back to IDLE: the held issue_valid_i belongs to the
            // instruction that is retiring now and must not relaunch.
            hilo_we_o  = done_q & ~flush_i;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         done_q            <= 1'b0;
         div.div_start_o   <= 1'b0;
         div.div_annul_o   <= 1'b0;
         div.div_signed_o  <= 1'b0;
         div.div_opdata1_o <= '0;
         div.div_opdata2_o <= '0;
         hi_o              <= '0;
         lo_o              <= '0;
         dbz_o             <= 1'b0;
      end else begin
         state           <= state_next;
         done_q          <= finish;
         div.div_annul_o <= kill | wdog_trip;
         if (launch) begin
            div.div_opdata1_o <= issue_op1_i;
            div.div_opdata2_o <= issue_op2_i;
            div.div_signed_o  <= issue_signed_i;
            div.div_start_o   <= 1'b1;
            dbz_o             <= (issue_op2_i == 32'd0);
         end
         if (finish) begin
            hi_o <= div.div_result_i[63:32];
            lo_o <= div.div_result_i[31:0];
         end
         if (finish || kill || wdog_trip) begin
            div.div_start_o <= 1'b0;
         end
      end
   end

`ifdef DIV_WATCHDOG_EN
   localparam int CNT_W = ($clog2(WDOG_LIMIT + 1) > 7) ? $clog2(WDOG_LIMIT + 1) : 7;

   logic [CNT_W-1:0] wdog_cnt;
   logic             wdog_err_q;

   // The count reaches WDOG_LIMIT-1 during the WDOG_LIMIT-th BUSY cycle.
   assign wdog_hit   = (wdog_cnt == CNT_W'(WDOG_LIMIT - 1));
   assign wdog_err_o = wdog_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_cnt   <= '0;
         wdog_err_q <= 1'b0;
      end else begin
         wdog_err_q <= wdog_trip;
         if (launch) begin
            wdog_cnt <= '0;
         end else if (state == BUSY) begin
            wdog_cnt <= wdog_cnt + 1'b1;
         end
      end
   end
`else
   assign wdog_hit   = 1'b0;
   assign wdog_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl: a pipeline driver issues divides, a
// behavioural divider answers, and a monitor checks every HI/LO write.
module tb_div_issue_ctrl;
   localparam int WDOG = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid_i, issue_signed_i, flush_i;
   logic [31:0] issue_op1_i, issue_op2_i;
   logic        stallreq_o, hilo_we_o, dbz_o, wdog_err_o;
   logic [31:0] hi_o, lo_o;

   div_issue_ctrl_if dif ();

   div_issue_ctrl #(.WDOG_LIMIT(WDOG)) dut (
      .clk           (clk),
      .rst           (rst),
      .issue_valid_i (issue_valid_i),
      .issue_signed_i(issue_signed_i),
      .issue_op1_i   (issue_op1_i),
      .issue_op2_i   (issue_op2_i),
      .flush_i       (flush_i),
      .stallreq_o    (stallreq_o),
      .div           (dif),
      .hilo_we_o     (hilo_we_o),
      .hi_o          (hi_o),
      .lo_o          (lo_o),
      .dbz_o         (dbz_o),
      .wdog_err_o    (wdog_err_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0, n_fail = 0;
   int   launches = 0, exp_launches = 0;
   int   annuls = 0, exp_annuls = 0;
   int   wdog_pulses = 0, exp_wdog = 0;
   int   force_lat = 0;
   bit   hang = 1'b0;

   // divider model state
   bit          dv_busy = 1'b0;
   logic        dv_prev = 1'b0;
   bit          dv_sgn;
   logic [31:0] dv_a, dv_b;
   int          dv_cnt, dv_lat;
   logic        prev_annul = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   // {remainder, quotient}; divide-by-zero yields zeros.
   function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      if (b == 32'd0) return 64'd0;
      if (!sgn) return {a % b, a / b};
      sa = a;
      sb = b;
      if (sa == (-2147483647 - 1) && sb == -1) return {32'd0, a};
      return {32'(sa % sb), 32'(sa / sb)};
   endfunction

   // Behavioural divider: one launch per rising start, result after a latency.
   initial begin
      dif.div_ready_i  = 1'b0;
      dif.div_result_i = '0;
      forever begin
         @(negedge clk);
         dif.div_ready_i = 1'b0;
         if (dif.div_start_o === 1'b1 && dv_prev !== 1'b1) begin
            launches++;
            dv_busy = 1'b1;
            dv_a    = dif.div_opdata1_o;
            dv_b    = dif.div_opdata2_o;
            dv_sgn  = dif.div_signed_o;
            dv_cnt  = 0;
            dv_lat  = (force_lat > 0) ? force_lat : int'($urandom_range(1, 20));
         end else if (dv_busy) begin
            if (dif.div_start_o !== 1'b1) begin
               dv_busy = 1'b0;
            end else begin
               check("operands_stable", {31'd0, dif.div_signed_o, dif.div_opdata1_o, dif.div_opdata2_o},
                     {31'd0, dv_sgn, dv_a, dv_b});
               dv_cnt++;
               if (dv_cnt >= dv_lat && !hang) begin
                  dif.div_ready_i  = 1'b1;
                  dif.div_result_i = ref_div(dv_sgn, dv_a, dv_b);
                  dv_busy          = 1'b0;
               end
            end
         end
         dv_prev = dif.div_start_o;
      end
   end

   // Monitor: every HI/LO write is matched against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (dif.div_annul_o === 1'b1) begin
            annuls++;
            check("annul_one_cycle", {63'd0, prev_annul}, 64'd0);
         end
         prev_annul = dif.div_annul_o;
         if (wdog_err_o === 1'b1) wdog_pulses++;
         if (hilo_we_o === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("hilo_we_unexpected", {63'd0, hilo_we_o}, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("hi", {32'd0, hi_o}, {32'd0, e.hi});
               check("lo", {32'd0, lo_o}, {32'd0, e.lo});
               check("dbz", {63'd0, dbz_o}, {63'd0, e.dbz});
               check("start_low_in_done", {63'd0, dif.div_start_o}, 64'd0);
               check("stall_low_in_done", {63'd0, stallreq_o}, 64'd0);
            end
         end
      end
   end

   // Pipeline driver: hold the instruction until stallreq_o lets it retire.
   task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, output int cycles);
      bit stall_s, fl_s;
      issue_valid_i  = 1'b1;
      issue_signed_i = sgn;
      issue_op1_i    = a;
      issue_op2_i    = b;
      exp_launches++;
      cycles = 0;
      forever begin
         #2;
         stall_s = stallreq_o;
         fl_s    = flush_i;
         @(posedge clk);
         #1;
         if (fl_s) begin
            flush_i       = 1'b0;
            issue_valid_i = 1'b0;
            return;
         end
         if (!stall_s) return;
         cycles++;
         if (cycles == flush_at) flush_i = 1'b1;
         if (cycles > 400) begin
            check("stall_release_timeout", 64'(cycles), 64'd0);
            issue_valid_i = 1'b0;
            return;
         end
      end
   endtask

   task automatic div_exp(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
      int c;
      exp_q.push_back('{hi: ehi, lo: elo, dbz: edbz});
      issue(sgn, a, b, -1, c);
   endtask

   task automatic div_flush(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                            input int lat, input int flush_at);
      int c;
      force_lat = lat;
      exp_annuls++;
      issue(sgn, a, b, flush_at, c);
      force_lat = 0;
   endtask

   task automatic idle(input int n);
      issue_valid_i = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      logic [63:0] r;
      bit          sgn;
      logic [31:0] a, b;
      int          c;

      rst = 1'b1; issue_valid_i = 1'b0; issue_signed_i = 1'b0; flush_i = 1'b0;
      issue_op1_i = '0; issue_op2_i = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #2;
      check("rst_stall", {63'd0, stallreq_o}, 64'd0);
      check("rst_start", {63'd0, dif.div_start_o}, 64'd0);
      check("rst_annul", {63'd0, dif.div_annul_o}, 64'd0);
      check("rst_signed", {63'd0, dif.div_signed_o}, 64'd0);
      check("rst_opdata", {dif.div_opdata1_o, dif.div_opdata2_o}, 64'd0);
      check("rst_hilo", {hi_o, lo_o}, 64'd0);
      check("rst_dbz_we_wdog", {61'd0, dbz_o, hilo_we_o, wdog_err_o}, 64'd0);
      @(posedge clk); #1;

      div_exp(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      idle(2);
      div_exp(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      idle(1);
      div_exp(1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 1'b1);
      idle(2);
      div_flush(1'b0, 32'd1000, 32'd3, 30, 10);
      idle(1);
      div_exp(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0);
      idle(2);
      // back-to-back with issue_valid_i held high between the two
      div_exp(1'b0, 32'd50, 32'd5, 32'd0, 32'd10, 1'b0);
      div_exp(1'b0, 32'd51, 32'd5, 32'd1, 32'd10, 1'b0);
      idle(2);
      // flush in the very cycle the divider reports ready
      div_flush(1'b0, 32'd77, 32'd7, 5, 6);
      idle(2);

      // reset while busy: silent abort, registers cleared
      issue_valid_i = 1'b1; issue_signed_i = 1'b0;
      issue_op1_i = 32'd123; issue_op2_i = 32'd4;
      exp_launches++;
      force_lat = 30;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0; issue_valid_i = 1'b0; force_lat = 0;
      #2;
      check("midop_rst_hilo", {hi_o, lo_o}, 64'd0);
      check("midop_rst_start", {62'd0, dif.div_start_o, stallreq_o}, 64'd0);
      idle(3);

      for (int i = 0; i < 40; i++) begin
         sgn = 1'($urandom_range(0, 1));
         a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1, 2:    b = 32'($urandom_range(1, 15));
            3:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 5) == 0) begin
            div_flush(sgn, a, b, 30, int'($urandom_range(1, 20)));
         end else begin
            r = ref_div(sgn, a, b);
            exp_q.push_back('{hi: r[63:32], lo: r[31:0], dbz: (b == 32'd0)});
            issue(sgn, a, b, -1, c);
         end
         if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
      end
      idle(2);

`ifdef DIV_WATCHDOG_EN
      hang = 1'b1;
      exp_wdog++;
      exp_annuls++;
      issue(1'b0, 32'd10, 32'd2, -1, c);
      check("wdog_release_cycle", 64'(c), 64'(WDOG + 1));
      hang = 1'b0;
      idle(3);
`endif

      idle(5);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      check("launch_count", 64'(launches), 64'(exp_launches));
      check("annul_count", 64'(annuls), 64'(exp_annuls));
      check("wdog_count", 64'(wdog_pulses), 64'(exp_wdog));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- EX-stage sequencer directly upstream of the multi-cycle divider.
- Accepts decoded DIV/DIVU operands from EX and launches the divider with the start/annul handshake.
- Stalls the pipeline while the divide runs, then produces a one-cycle HI/LO write with the 64-bit result.
- Never relaunches the same instruction; handles pipeline flush mid-operation.

Parameters:
- WDOG_LIMIT, 64, max cycles in BUSY before abort (used only with DIV_WATCHDOG_EN).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- issue_valid_i  in  1  EX holds DIV/DIVU; held high by pipeline while stalled
- issue_signed_i  in  1  1 = DIV, 0 = DIVU
- issue_op1_i  in  32  dividend
- issue_op2_i  in  32  divisor
- flush_i  in  1  pipeline flush (exception); kills in-flight divide
- stallreq_o  out  1  stall request to pipeline control
- div_start_o  out  1  divider start (1 = start, 0 = stop)
- div_annul_o  out  1  divider annul
- div_signed_o  out  1  signed-divide select to divider
- div_opdata1_o  out  32  latched dividend
- div_opdata2_o  out  32  latched divisor
- div_result_i  in  64  {remainder, quotient} from divider
- div_ready_i  in  1  divider result ready
- hilo_we_o  out  1  HI/LO write enable, one-cycle pulse
- hi_o  out  32  remainder
- lo_o  out  32  quotient
- dbz_o  out  1  divisor was zero; valid with hilo_we_o
- wdog_err_o  out  1  watchdog abort pulse

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; all registered outputs 0, including start, annul, signed, opdata, hi, lo, dbz, done flag and watchdog counter.
- Reset mid-operation aborts silently; no hilo_we_o.
- Registers hold state, latched operands, start, annul, result and the done flag.
- stallreq_o is combinational.
- IDLE:
  - stallreq_o = issue_valid_i & ~flush_i.
  - If issue_valid_i & ~flush_i: latch op1, op2, signed; div_start_o<=1; dbz<=(op2==0); ->BUSY.
- BUSY:
  - stallreq_o=1; div_start_o stays 1; operands held stable.
  - If flush_i: div_annul_o<=1 for exactly one cycle, div_start_o<=0, ->IDLE, no write. Flush has priority over div_ready_i in the same cycle.
  - Else if div_ready_i: hi<=div_result_i[63:32], lo<=div_result_i[31:0], done<=1, div_start_o<=0, ->DONE.
- DONE:
  - stallreq_o=0, so the instruction advances at the end of this cycle.
  - hilo_we_o = done & ~flush_i.
  - done<=0; ->IDLE unconditionally, ignoring issue_valid_i; this prevents relaunch.
- Operand changes on issue_* inputs while in BUSY/DONE are ignored.
- Overhead: 1 launch cycle + 1 DONE cycle on top of divider latency.
- Back-to-back divides: second launch occurs in the IDLE cycle after DONE. div_start_o was low for at least 2 cycles, so the divider is free.
- div_annul_o is 0 except the flush pulse.
- hi_o/lo_o/dbz_o hold their last values between writes.

Optional Feature:
- Macro: DIV_WATCHDOG_EN.
- With macro:
  - A 7-bit-minimum counter clears on entry to BUSY and increments each BUSY cycle.
  - On reaching WDOG_LIMIT without div_ready_i: div_annul_o pulse, div_start_o<=0, wdog_err_o=1 for one cycle, ->DONE with hilo_we_o suppressed. This releases the stall without a write.
- Without macro: no counter; wdog_err_o tied 0; BUSY waits indefinitely.

Test Plan:
- DIVU 100/7 -> stall until ready, one DONE cycle, hilo_we_o=1, hi_o=2, lo_o=14, dbz_o=0, div_start_o low in DONE.
- DIV 0xFFFFFFF9(-7)/2 -> div_signed_o=1, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFD.
- DIVU 5/0 -> dbz_o=1, hilo_we_o=1, hi_o=lo_o=0, stall released normally.
- DIVU 1000/3 with flush_i asserted 10 cycles after launch -> one-cycle div_annul_o, ->IDLE, hilo_we_o never 1. Next DIVU 9/3 -> lo_o=3, hi_o=0.
- Two consecutive DIVU (50/5 then 51/5) with issue_valid_i held high throughout -> exactly two launches, two hilo_we_o pulses: (hi,lo)=(0,10) then (1,10).
- DIV_WATCHDOG_EN, WDOG_LIMIT=8, div_ready_i tied 0 -> at BUSY cycle 8 annul and wdog_err_o pulse, stallreq_o drops next cycle, no hilo_we_o.
